// File: rtl/board_writer.sv
// board_writer: accepts a post-move 2048 board for one of two banks, spawns
// a tile in a pseudo-random empty cell, and commits board + occupancy mask.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for an offer; wr_ready high
// ST_SCAN   | walking cells from the random start index looking for a hole
// ST_COMMIT | writing the latched board, mask and full flag to the bank
`timescale 1ns/1ps

module board_writer #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  mode,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [63:0] wr_num,
   input  logic        wr_moved,
   input  logic        clear,
   output logic [63:0] num1,
   output logic [63:0] num2,
   output logic [15:0] judge1,
   output logic [15:0] judge2,
   output logic        full1,
   output logic        full2,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [15:0] lfsr;
   logic        lfsr_fb;

   logic [63:0] buf_num;
   logic        buf_bank2;
   logic [3:0]  idx;
   logic [3:0]  tile;
   logic [3:0]  scan_cnt;
   logic        exhausted;
   logic [15:0] buf_judge;

   logic        sel_bank2;
   logic        cell_empty;
   logic        accept;
   logic        scan_hit;
   logic        scan_last;
   logic        do_commit;

   assign sel_bank2  = (mode == 4'd2);
   assign cell_empty = (buf_num[{idx, 2'b00} +: 4] == 4'd0);
   assign wr_ready   = (state == ST_IDLE);

   // Fibonacci LFSR, taps 16,14,13,11 in right-shift form; nonzero seed keeps it out of the lock-up state.
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   // Free-running LFSR, advanced every cycle after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr_fb, lfsr[15:1]};
      end
   end

   // Occupancy mask of the latched board; committed alongside it.
   always_comb begin
      buf_judge = '0;
      for (int i = 0; i < 16; i++) begin
         buf_judge[i] = |buf_num[4*i +: 4];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control strobes; clear overrides everything, including a same-cycle offer.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      scan_hit  = 1'b0;
      scan_last = 1'b0;
      do_commit = 1'b0;
      if (clear) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wr_valid) begin
                  accept    = 1'b1;
                  state_nxt = wr_moved ? ST_SCAN : ST_COMMIT;
               end
            end
            ST_SCAN: begin
               if (cell_empty) begin
                  scan_hit  = 1'b1;
                  state_nxt = ST_COMMIT;
               end else if (scan_cnt == 4'd15) begin
                  scan_last = 1'b1;
                  state_nxt = ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               do_commit = 1'b1;
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Working copy of the board plus scan bookkeeping; the spawn lands here before commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_num   <= '0;
         buf_bank2 <= 1'b0;
         idx       <= '0;
         tile      <= '0;
         scan_cnt  <= '0;
         exhausted <= 1'b0;
      end else if (clear) begin
         buf_num   <= '0;
         buf_bank2 <= 1'b0;
         scan_cnt  <= '0;
         exhausted <= 1'b0;
      end else if (accept) begin
         buf_num   <= wr_num;
         buf_bank2 <= sel_bank2;
         idx       <= lfsr[3:0];
         tile      <= (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
         scan_cnt  <= '0;
         exhausted <= 1'b0;
      end else if (scan_hit) begin
         buf_num[{idx, 2'b00} +: 4] <= tile;
      end else if (state == ST_SCAN) begin
         idx      <= idx + 4'd1;
         scan_cnt <= scan_cnt + 4'd1;
         if (scan_last) begin
            exhausted <= 1'b1;
         end
      end
   end

   // Bank registers: clear zeroes the mode-selected bank, commit writes the latched bank only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num1   <= '0;
         num2   <= '0;
         judge1 <= '0;
         judge2 <= '0;
         full1  <= 1'b0;
         full2  <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= do_commit;
         if (clear) begin
            if (sel_bank2) begin
               num2   <= '0;
               judge2 <= '0;
               full2  <= 1'b0;
            end else begin
               num1   <= '0;
               judge1 <= '0;
               full1  <= 1'b0;
            end
         end else if (do_commit) begin
            if (buf_bank2) begin
               num2   <= buf_num;
               judge2 <= buf_judge;
               full2  <= exhausted;
            end else begin
               num1   <= buf_num;
               judge1 <= buf_judge;
               full1  <= exhausted;
            end
         end
      end
   end

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: reset, LFSR sequence, plain commit,
// spawn into the last hole, full board, clear mid-scan, reset mid-scan.
`timescale 1ns/1ps

module tb_board_writer;

   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  mode;
   logic        wr_valid;
   logic        wr_ready;
   logic [63:0] wr_num;
   logic        wr_moved;
   logic        clear;
   logic [63:0] num1, num2;
   logic [15:0] judge1, judge2;
   logic        full1, full2;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_lfsr;

   board_writer #(.SEED(SEED)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_num   (wr_num),
      .wr_moved (wr_moved),
      .clear    (clear),
      .num1     (num1),
      .num2     (num2),
      .judge1   (judge1),
      .judge2   (judge2),
      .full1    (full1),
      .full2    (full2),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^16+x^14+x^13+x^11, bits shifted toward bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      logic b;
      b = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'h1;
      return (x >> 1) | (16'(b) << 15);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= SEED;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   // Expected result of a spawn starting at s: new board, edges to commit, full flag.
   function automatic void model_spawn(input logic [63:0] b, input logic [3:0] s,
                                       input logic [3:0] t, output logic [63:0] nb,
                                       output int lat, output logic fl);
      logic [3:0] k;
      logic       found;
      nb = b; lat = 18; fl = 1'b1; k = s; found = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         if (!found && nb[{k, 2'b00} +: 4] == 4'd0) begin
            nb[{k, 2'b00} +: 4] = t;
            lat   = n + 2;
            fl    = 1'b0;
            found = 1'b1;
         end
         k = k + 4'd1;
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " num1"}, num1, 64'h0);
      chk({tag, " num2"}, num2, 64'h0);
      chk({tag, " judge1"}, 64'(judge1), 64'h0);
      chk({tag, " judge2"}, 64'(judge2), 64'h0);
      chk({tag, " full1"}, 64'(full1), 64'h0);
      chk({tag, " full2"}, 64'(full2), 64'h0);
      chk({tag, " done"}, 64'(done), 64'h0);
      chk({tag, " wr_ready"}, 64'(wr_ready), 64'h1);
   endtask

   // Offer one board, then count edges (accept edge = 1) until done rises.
   task automatic do_write(input string tag, input logic [3:0] m, input logic mv,
                           input logic [63:0] b, output int lat);
      mode = m; wr_moved = mv; wr_num = b; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      wr_num   = 64'hDEAD_BEEF_DEAD_BEEF;
      mode     = 4'd0;
      lat      = 1;
      chk({tag, " busy"}, 64'(wr_ready), 64'h0);
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      assert (done === 1'b1) else begin
         errors++;
         $error("FAIL %s timeout: observed no done after %0d edges expected done", tag, lat);
         lat = 0;
      end
   endtask

   initial begin
      logic [63:0] exp_b;
      logic [63:0] b;
      int          exp_lat;
      int          lat;
      logic        exp_full;
      logic [3:0]  s, t;

      rst_n = 1'b0; mode = 4'd0; wr_valid = 1'b0; wr_num = '0;
      wr_moved = 1'b0; clear = 1'b0;
      #2;
      chk_reset_vals("reset");
      tick(); tick(); tick();
      rst_n = 1'b1;

      // LFSR sequence against the reference for 100 cycles
      chk("lfsr seed", 64'(dut.lfsr), 64'(SEED));
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("lfsr seq", 64'(dut.lfsr), 64'(m_lfsr));
      end

      // plain commit to bank 1, no spawn
      do_write("plain", 4'd1, 1'b0, 64'h0000_0000_0000_1234, lat);
      chk("plain latency", 64'(lat), 64'd2);
      chk("plain num1", num1, 64'h0000_0000_0000_1234);
      chk("plain judge1", 64'(judge1), 64'h000F);
      chk("plain full1", 64'(full1), 64'h0);
      chk("plain num2", num2, 64'h0);
      chk("plain ready", 64'(wr_ready), 64'h1);
      tick();
      chk("plain done 1cyc", 64'(done), 64'h0);

      // spawn into the single hole of bank 2
      b = 64'h1111_1111_1111_1110;
      s = m_lfsr[3:0];
      t = (m_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
      model_spawn(b, s, t, exp_b, exp_lat, exp_full);
      do_write("hole", 4'd2, 1'b1, b, lat);
      chk("hole latency", 64'(lat), 64'(exp_lat));
      chk("hole num2", num2, exp_b);
      chk("hole cell0 range", 64'(num2[3:0] == 4'd1 || num2[3:0] == 4'd2), 64'h1);
      chk("hole judge2", 64'(judge2), 64'hFFFF);
      chk("hole full2", 64'(full2), 64'h0);
      chk("hole num1 kept", num1, 64'h0000_0000_0000_1234);
      chk("hole judge1 kept", 64'(judge1), 64'h000F);

      // full board to bank 1: no spawn, full flag set
      do_write("full", 4'd1, 1'b1, 64'h2121_2121_2121_2121, lat);
      chk("full latency", 64'(lat), 64'd18);
      chk("full num1", num1, 64'h2121_2121_2121_2121);
      chk("full judge1", 64'(judge1), 64'hFFFF);
      chk("full full1", 64'(full1), 64'h1);
      chk("full full2", 64'(full2), 64'h0);
      tick();
      chk("full done 1cyc", 64'(done), 64'h0);

      // later spawn with room clears full1; mode 7 also selects bank 1
      b = 64'h0000_0000_0000_0005;
      s = m_lfsr[3:0];
      t = (m_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
      model_spawn(b, s, t, exp_b, exp_lat, exp_full);
      do_write("refill", 4'd7, 1'b1, b, lat);
      chk("refill latency", 64'(lat), 64'(exp_lat));
      chk("refill num1", num1, exp_b);
      chk("refill full1", 64'(full1), 64'h0);
      chk("refill num2 kept", num2, 64'h1111_1111_1111_1110 | 64'(num2[3:0]));

      // clear three cycles into a scan for bank 1; same-cycle offer ignored
      tick();
      mode = 4'd1; wr_moved = 1'b1; wr_num = 64'h2121_2121_2121_2121; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      tick(); tick(); tick();
      clear = 1'b1; wr_valid = 1'b1; mode = 4'd1; wr_moved = 1'b0; wr_num = 64'h0000_0000_0000_00FF;
      tick();
      clear = 1'b0; wr_valid = 1'b0;
      chk("clear num1", num1, 64'h0);
      chk("clear judge1", 64'(judge1), 64'h0);
      chk("clear full1", 64'(full1), 64'h0);
      chk("clear done", 64'(done), 64'h0);
      chk("clear ready", 64'(wr_ready), 64'h1);
      chk("clear num2 kept", 64'(judge2), 64'hFFFF);
      tick();
      chk("clear no accept num1", num1, 64'h0);
      chk("clear no accept done", 64'(done), 64'h0);
      chk("clear no accept ready", 64'(wr_ready), 64'h1);

      // asynchronous reset in the middle of a scan
      mode = 4'd2; wr_moved = 1'b1; wr_num = 64'h2121_2121_2121_2121; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      tick();
      rst_n = 1'b1;
      chk("midreset lfsr", 64'(dut.lfsr), 64'(SEED));

      // first accept after reset: lfsr=ACE1 -> start 1, tile 1
      do_write("post", 4'd1, 1'b1, 64'h0, lat);
      chk("post latency", 64'(lat), 64'd3);
      chk("post num1", num1, 64'h0000_0000_0000_0010);
      chk("post judge1", 64'(judge1), 64'h0002);
      chk("post num2", num2, 64'h0);
      chk("post full1", 64'(full1), 64'h0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
